// File: rtl/lifo_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : lifo_cmd_seq
// Purpose  : Command sequencer in front of a LIFO with a one-cycle EN strobe.
//            It accepts push/pop requests over valid/ready handshakes and
//            issues one LIFO operation at a time. It returns popped data, or
//            an underflow error, over a held response channel.
// Revision : 1.0 - initial release
//
// Optional feature macro: LIFO_CMD_SEQ_STATS_EN
//   When defined, adds the saturating 8-bit statistics outputs
//   push_cnt / pop_cnt / uflow_cnt.
//
// Ports
//   Clk, Rst          : single clock, synchronous active-high reset
//   push_valid/ready  : push request handshake, payload push_data[WIDTH]
//   pop_valid/ready   : pop request handshake (pop has priority over push)
//   rsp_valid/ready   : response handshake; rsp_data[WIDTH], rsp_err=underflow
//   lifo_dataIn/RW/EN : command outputs to the LIFO (RW: 0 push, 1 pop)
//   lifo_dataOut      : read data from the LIFO
//   lifo_EMPTY/FULL   : LIFO status inputs
//   push_cnt/pop_cnt/uflow_cnt : statistics (only with LIFO_CMD_SEQ_STATS_EN)
// ============================================================================
module lifo_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_valid,
  output logic             pop_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] lifo_dataIn,
  output logic             lifo_RW,
  output logic             lifo_EN,
  input  logic [WIDTH-1:0] lifo_dataOut,
  input  logic             lifo_EMPTY,
`ifdef LIFO_CMD_SEQ_STATS_EN
  input  logic             lifo_FULL,
  output logic [7:0]       push_cnt,
  output logic [7:0]       pop_cnt,
  output logic [7:0]       uflow_cnt
`else
  input  logic             lifo_FULL
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_ISS = 3'd1,
    POP_ISS  = 3'd2,
    POP_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             lifo_en_q,   lifo_en_d;
  logic             lifo_rw_q,   lifo_rw_d;
  logic [WIDTH-1:0] lifo_din_q,  lifo_din_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic             rsp_err_q,   rsp_err_d;

  logic w_idle;
  logic w_pop_acc;
  logic w_push_acc;
  logic w_underflow;

  // Handshakes are only offered in IDLE and never while reset is asserted.
  // A pending pop request masks push_ready so pop always wins.
  assign w_idle      = (state_q == IDLE) && !Rst;
  assign pop_ready   = w_idle;
  assign push_ready  = w_idle && !pop_valid && (count_q < C_DEPTH) && !lifo_FULL;
  assign w_pop_acc   = pop_valid && pop_ready;
  assign w_push_acc  = push_valid && push_ready;
  // Either the local occupancy count or the LIFO itself reporting empty
  // turns the pop into an underflow that never touches the LIFO.
  assign w_underflow = (count_q == '0) || lifo_EMPTY;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lifo_en_d   = 1'b0;      // EN is a single-cycle strobe
    lifo_rw_d   = lifo_rw_q; // RW and dataIn hold their last value
    lifo_din_d  = lifo_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (w_pop_acc) begin
          if (w_underflow) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = POP_ISS;
            lifo_en_d = 1'b1;
            lifo_rw_d = 1'b1;
          end
        end else if (w_push_acc) begin
          // Registering the payload here makes it appear on lifo_dataIn
          // in the same cycle as the EN strobe.
          state_d    = PUSH_ISS;
          lifo_en_d  = 1'b1;
          lifo_rw_d  = 1'b0;
          lifo_din_d = push_data;
        end
      end
      PUSH_ISS: begin
        if (count_q < C_DEPTH) count_d = count_q + CNT_W'(1);
        state_d = IDLE;
      end
      POP_ISS: begin
        if (count_q != '0) count_d = count_q - CNT_W'(1);
        state_d = POP_WAIT;
      end
      POP_WAIT: begin
        // The LIFO presents the popped word the cycle after the EN strobe.
        rsp_data_d  = lifo_dataOut;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LIFO_CMD_SEQ_STATS_EN
  logic [7:0] push_cnt_q,  push_cnt_d;
  logic [7:0] pop_cnt_q,   pop_cnt_d;
  logic [7:0] uflow_cnt_q, uflow_cnt_d;

  always_comb begin
    push_cnt_d  = push_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    uflow_cnt_d = uflow_cnt_q;
    if ((state_q == PUSH_ISS) && (push_cnt_q != 8'hFF))
      push_cnt_d = push_cnt_q + 8'd1;
    if ((state_q == POP_ISS) && (pop_cnt_q != 8'hFF))
      pop_cnt_d = pop_cnt_q + 8'd1;
    if (w_pop_acc && w_underflow && (uflow_cnt_q != 8'hFF))
      uflow_cnt_d = uflow_cnt_q + 8'd1;
  end

  assign push_cnt  = push_cnt_q;
  assign pop_cnt   = pop_cnt_q;
  assign uflow_cnt = uflow_cnt_q;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      lifo_en_q   <= 1'b0;
      lifo_rw_q   <= 1'b0;
      lifo_din_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef LIFO_CMD_SEQ_STATS_EN
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      uflow_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lifo_en_q   <= lifo_en_d;
      lifo_rw_q   <= lifo_rw_d;
      lifo_din_q  <= lifo_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LIFO_CMD_SEQ_STATS_EN
      push_cnt_q  <= push_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      uflow_cnt_q <= uflow_cnt_d;
`endif
    end
  end

  assign lifo_EN     = lifo_en_q;
  assign lifo_RW     = lifo_rw_q;
  assign lifo_dataIn = lifo_din_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lifo_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_cmd_seq
// Purpose  : Self-checking bench for lifo_cmd_seq. It contains a behavioural
//            8-entry LIFO on the command port and a queue-based stack model
//            that predicts every response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lifo_cmd_seq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic             pop_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             rsp_ready;
  logic [WIDTH-1:0] lifo_dataIn;
  logic             lifo_RW;
  logic             lifo_EN;
  logic [WIDTH-1:0] lifo_dataOut;
  logic             lifo_EMPTY;
  logic             lifo_FULL;
`ifdef LIFO_CMD_SEQ_STATS_EN
  logic [7:0]       push_cnt, pop_cnt, uflow_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int push_strobes = 0;

  // Reference model: the sequence of accepted, still-stored push values.
  logic [WIDTH-1:0] ref_stk [$];

  always #5 Clk = ~Clk;

  lifo_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .rsp_ready    (rsp_ready),
    .lifo_dataIn  (lifo_dataIn),
    .lifo_RW      (lifo_RW),
    .lifo_EN      (lifo_EN),
    .lifo_dataOut (lifo_dataOut),
    .lifo_EMPTY   (lifo_EMPTY),
`ifdef LIFO_CMD_SEQ_STATS_EN
    .lifo_FULL    (lifo_FULL),
    .push_cnt     (push_cnt),
    .pop_cnt      (pop_cnt),
    .uflow_cnt    (uflow_cnt)
`else
    .lifo_FULL    (lifo_FULL)
`endif
  );

  // Behavioural LIFO sharing Clk/Rst; read data is registered on a pop.
  logic [WIDTH-1:0] mem [DEPTH];
  int               sp = 0;
  assign lifo_EMPTY = (sp == 0);
  assign lifo_FULL  = (sp == DEPTH);

  always @(posedge Clk) begin
    if (Rst) begin
      sp           <= 0;
      lifo_dataOut <= '0;
    end else if (lifo_EN) begin
      if (!lifo_RW && sp < DEPTH) begin
        mem[sp] <= lifo_dataIn;
        sp      <= sp + 1;
      end else if (lifo_RW && sp > 0) begin
        lifo_dataOut <= mem[sp-1];
        sp           <= sp - 1;
      end
    end
  end

  always @(posedge Clk) begin
    if (lifo_EN && !lifo_RW) push_strobes <= push_strobes + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic do_push(input logic [WIDTH-1:0] d);
    bit exp_rdy;
    exp_rdy    = (ref_stk.size() < DEPTH);
    push_valid = 1'b1;
    push_data  = d;
    pop_valid  = 1'b0;
    #1 chk("push_ready", push_ready, exp_rdy);
    tick();
    push_valid = 1'b0;
    if (exp_rdy) begin
      chk("push_iss_en", lifo_EN, 1);
      chk("push_iss_rw", lifo_RW, 0);
      chk("push_iss_din", lifo_dataIn, d);
      ref_stk.push_back(d);
      tick();
      chk("push_after_en", lifo_EN, 0);
      chk("push_din_hold", lifo_dataIn, d);
    end else begin
      chk("push_blocked_en", lifo_EN, 0);
    end
  endtask

  // Pop with an optional response stall; rst_abort applies reset while the
  // response is still being held instead of consuming it.
  task automatic do_pop(input int stall, input bit rst_abort);
    logic [WIDTH-1:0] exp_d;
    bit               uf;
    uf = (ref_stk.size() == 0);
    if (uf) exp_d = '0;
    else    exp_d = ref_stk.pop_back();
    pop_valid  = 1'b1;
    push_valid = 1'b0;
    rsp_ready  = (stall == 0);
    #1 chk("pop_ready", pop_ready, 1);
    tick();
    pop_valid = 1'b0;
    if (!uf) begin
      chk("pop_iss_en", lifo_EN, 1);
      chk("pop_iss_rw", lifo_RW, 1);
      chk("pop_iss_rsp_valid", rsp_valid, 0);
      tick();
      chk("pop_wait_en", lifo_EN, 0);
      chk("pop_wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, uf);
    chk("rsp_data", rsp_data, exp_d);
    chk("resp_en", lifo_EN, 0);
    chk("resp_pop_ready", pop_ready, 0);
    repeat (stall) begin
      tick();
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_data", rsp_data, exp_d);
      chk("rsp_hold_err", rsp_err, uf);
    end
    if (rst_abort) begin
      Rst = 1'b1;
      tick();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_data", rsp_data, 0);
      Rst = 1'b0;
      ref_stk.delete();
    end else begin
      rsp_ready = 1'b1;
      tick();
      chk("rsp_consumed", rsp_valid, 0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] exp_d;
    int               s0;

    // Reset held for two cycles with a push request pending.
    Rst        = 1'b1;
    push_valid = 1'b1;
    push_data  = 4'h5;
    pop_valid  = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      chk("rst_push_ready", push_ready, 0);
      chk("rst_lifo_en", lifo_EN, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end
    chk("rst_lifo_rw", lifo_RW, 0);
    chk("rst_lifo_din", lifo_dataIn, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    Rst        = 1'b0;
    push_valid = 1'b0;

    // Ordered push/pop: responses come back in reverse order.
    for (int i = 0; i < 4; i++) do_push(4'(2 * i));
    for (int i = 0; i < 4; i++) do_pop(0, 1'b0);

    // Pop on empty.
    do_pop(0, 1'b0);

    // Fill to DEPTH and attempt a ninth push.
    s0 = push_strobes;
    for (int i = 0; i < 9; i++) do_push(4'(i + 1));
    chk("fill_strobes", push_strobes - s0, DEPTH);
    push_valid = 1'b1;
    push_data  = 4'h9;
    repeat (3) begin
      #1 chk("full_push_ready", push_ready, 0);
      tick();
      chk("full_no_en", lifo_EN, 0);
    end
    do_pop(1, 1'b0);
    do_push(4'h9);

    // Drain, then two entries for the simultaneous request case.
    while (ref_stk.size() > 0) do_pop(0, 1'b0);
    do_push(4'h3);
    do_push(4'h7);
    push_valid = 1'b1;
    push_data  = 4'hA;
    pop_valid  = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    chk("both_pop_ready", pop_ready, 1);
    chk("both_push_ready", push_ready, 0);
    exp_d = ref_stk.pop_back();
    tick();
    pop_valid = 1'b0;
    chk("both_pop_iss_en", lifo_EN, 1);
    chk("both_pop_iss_rw", lifo_RW, 1);
    chk("both_busy_push_ready", push_ready, 0);
    tick();
    tick();
    chk("both_rsp_valid", rsp_valid, 1);
    chk("both_rsp_data", rsp_data, exp_d);
    chk("both_resp_push_ready", push_ready, 0);
    tick();
    chk("both_idle_push_ready", push_ready, 1);
    tick();
    push_valid = 1'b0;
    chk("both_push_en", lifo_EN, 1);
    chk("both_push_rw", lifo_RW, 0);
    chk("both_push_din", lifo_dataIn, 4'hA);
    ref_stk.push_back(4'hA);
    tick();
    chk("both_push_en_off", lifo_EN, 0);

    // Randomized mix checked against the stack model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) do_push(4'($urandom()));
      else                           do_pop(int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset while a response is held; the next pop must underflow.
    while (ref_stk.size() > 0) do_pop(0, 1'b0);
    do_push(4'hC);
    do_pop(5, 1'b1);
    do_pop(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lifo_cmd_seq.md
LIFO_CMD_SEQ -- requirements
Module: lifo_cmd_seq

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 4, data width of push/pop payload and LIFO data ports.
- DEPTH, 8, LIFO capacity in entries; CNT_W = clog2(DEPTH+1).
REQ-002 Ports SHALL be:
- Clk  in  1  single clock, all state on rising edge.
- Rst  in  1  synchronous, active-high reset.
- push_valid  in  1  push request.
- push_data  in  WIDTH  push payload.
- push_ready  out  1  push accepted when push_valid & push_ready.
- pop_valid  in  1  pop request.
- pop_ready  out  1  pop accepted when pop_valid & pop_ready.
- rsp_valid  out  1  pop response available.
- rsp_data  out  WIDTH  popped value (0 on underflow).
- rsp_err  out  1  underflow flag qualifying rsp_valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- lifo_dataIn  out  WIDTH  to LIFO dataIn.
- lifo_RW  out  1  to LIFO RW (0 push, 1 pop).
- lifo_EN  out  1  to LIFO EN, one-cycle strobe per operation.
- lifo_dataOut  in  WIDTH  from LIFO dataOut.
- lifo_EMPTY, lifo_FULL  in  1 each  LIFO status.
REQ-003 Clocking SHALL be one clock; Rst SHALL be synchronous and active-high; the attached LIFO SHALL share Clk and Rst.

Function
REQ-004 FSM states SHALL be IDLE, PUSH_ISS, POP_ISS, POP_WAIT, RESP; one LIFO operation in flight at a time.
REQ-005 push_ready and pop_ready SHALL be combinational and asserted only in IDLE.
REQ-006 Pop priority: in IDLE pop_ready=1; push_ready=1 only if pop_valid=0, count<DEPTH and lifo_FULL=0.
REQ-007 Accepted push SHALL register push_data; next cycle (PUSH_ISS) lifo_EN=1, lifo_RW=0, lifo_dataIn=data for exactly one cycle; count+1; return to IDLE.
REQ-008 Accepted pop with count>0 and lifo_EMPTY=0 SHALL go to POP_ISS: lifo_EN=1, lifo_RW=1 for one cycle; count-1; then POP_WAIT.
REQ-009 POP_WAIT SHALL capture lifo_dataOut into rsp_data at end of that cycle, then enter RESP.
REQ-010 Accepted pop with count==0 or lifo_EMPTY=1 SHALL skip LIFO access, go directly to RESP with rsp_data=0, rsp_err=1.
REQ-011 RESP SHALL hold rsp_valid=1 and stable rsp_data/rsp_err until rsp_ready=1; then IDLE next cycle.
REQ-012 Latency: push accept to lifo_EN = 1 cycle; pop accept to rsp_valid = 3 cycles (valid), 1 cycle (underflow).
REQ-013 Outside PUSH_ISS/POP_ISS lifo_EN SHALL be 0; lifo_RW and lifo_dataIn SHALL hold last value.
REQ-014 count SHALL saturate in [0, DEPTH]; no push issued at DEPTH, no pop issued at 0.
REQ-015 Throughput: max one push per 2 cycles; one pop per 4 cycles with rsp_ready tied high.

Reset
REQ-016 Rst=1 at a rising edge SHALL force IDLE, count=0, lifo_EN=0, lifo_RW=0, lifo_dataIn=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-017 Rst mid-operation SHALL abandon any pending push/pop and discard any held response without error indication.

Configuration
REQ-018 Macro LIFO_CMD_SEQ_STATS_EN defined: add outputs push_cnt, pop_cnt, uflow_cnt (8 bits each, saturating at 255, cleared by Rst), incremented on PUSH_ISS, POP_ISS, and underflow accept respectively.
REQ-019 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-020 Reset: Rst=1 for 2 cycles with push_valid=1 -> push_ready=0, lifo_EN=0, rsp_valid=0 throughout.
REQ-021 Push 0x0,0x2,0x4,0x6 then 4 pops with rsp_ready=1 -> rsp_data 0x6,0x4,0x2,0x0, rsp_err=0, each 3 cycles after accept.
REQ-022 Pop on empty -> rsp_valid with rsp_err=1, rsp_data=0 one cycle after accept, lifo_EN stays 0.
REQ-023 Push 9 values with DEPTH=8 -> 8 EN strobes; push_ready stays 0 on the 9th until a pop completes.
REQ-024 push_valid and pop_valid together with count=2 -> pop accepted first, push accepted in next IDLE.
REQ-025 rsp_ready=0 for 5 cycles then Rst=1 -> rsp_valid drops next cycle, count=0, next pop underflows.
